multicycle_control: RTL

//  Multi-cycle sequencer for the 2-bit-opcode datapath (R-type, ADDI, LW, SW) sharing one memory port for

---
 rtl/ctrl_pkg.sv | 36 +++
 rtl/opcode_decode.sv | 24 ++
 rtl/multicycle_control.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle sequencer: opcode values carried in
// IR[15:14], the FSM state encoding (3-bit binary) and the bundle of
// opcode-dependent datapath selects produced by opcode_decode.
// ----------------------------------------------------------------------------
package ctrl_pkg;

   // Opcode field values
   localparam logic [1:0] OP_RTYPE = 2'b00;
   localparam logic [1:0] OP_ADDI  = 2'b01;
   localparam logic [1:0] OP_LW    = 2'b10;
   localparam logic [1:0] OP_SW    = 2'b11;

   // Sequencer states
   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_ERROR  = 3'd5;

   // Opcode-dependent datapath selects
   typedef struct packed {
      logic reg_dst;     // 1: write rd, 0: write rt
      logic alu_src;     // 1: ALU B = sign-extended immediate
      logic mem_to_reg;  // 1: writeback data from memory
      logic alu_op;      // 1: funct/add per opcode, 0: address add
   } dec_ctrl_t;

   // Loads and stores both carry opcode bit 1 and need a MEM step
   function automatic logic is_mem_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/opcode_decode.sv
// ----------------------------------------------------------------------------
// opcode_decode
// Pure combinational translation of the latched opcode into the datapath
// selects that depend only on the instruction type.
// Ports:
//   i_op   in  2   latched opcode (op_q)
//   o_dec  out 4   {reg_dst, alu_src, mem_to_reg, alu_op}
// ----------------------------------------------------------------------------
module opcode_decode
   import ctrl_pkg::*;
(
   input  logic [1:0] i_op,
   output dec_ctrl_t  o_dec
);

   always_comb begin
      o_dec            = '0;
      o_dec.reg_dst    = (i_op == OP_RTYPE);
      o_dec.alu_src    = (i_op != OP_RTYPE);
      o_dec.mem_to_reg = (i_op == OP_LW);
      o_dec.alu_op     = ~i_op[1];
   end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle sequencer for the 2-bit-opcode datapath (R-type, ADDI, LW, SW)
// sharing one memory port between instruction fetch and data access. Steps
// each instruction through FETCH/DECODE/EXEC/MEM/WB, stretches FETCH and MEM
// while the memory is not ready, and traps to a sticky ERROR state when an
// access waits too long.
// Ports:
//   i_clk          in   1      clock, rising edge
//   i_rst          in   1      asynchronous active-high reset
//   i_opcode       in   2      IR[15:14], sampled at the end of DECODE
//   i_mem_ready    in   1      memory completes the current access
//   i_hold         in   1      idle in FETCH before a fetch is issued
//   o_pc_write     out  1      PC <= PC+2
//   o_ir_write     out  1      IR <= memory read data
//   o_iord         out  1      0: address = PC, 1: address = ALU result
//   o_reg_dst      out  1      1: write rd, 0: write rt
//   o_alu_src      out  1      1: ALU B = immediate
//   o_mem_to_reg   out  1      1: writeback from memory
//   o_reg_write    out  1      register file write enable
//   o_mem_read     out  1      memory read request
//   o_mem_write    out  1      memory write request
//   o_alu_op       out  1      1: funct/add per opcode, 0: address add
//   o_busy         out  1      0 only when idling in FETCH on hold
//   o_error        out  1      sticky memory timeout flag
//   o_instr_count  out  CNT_W  retired instructions (wraps)
// ----------------------------------------------------------------------------
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [1:0]       i_opcode,
   input  logic             i_mem_ready,
   input  logic             i_hold,
   output logic             o_pc_write,
   output logic             o_ir_write,
   output logic             o_iord,
   output logic             o_reg_dst,
   output logic             o_alu_src,
   output logic             o_mem_to_reg,
   output logic             o_reg_write,
   output logic             o_mem_read,
   output logic             o_mem_write,
   output logic             o_alu_op,
   output logic             o_busy,
   output logic             o_error,
   output logic [CNT_W-1:0] o_instr_count
);

   // MEM_TIMEOUT is at most 255, so the last legal wait value fits in 8 bits
   localparam int               WAIT_W    = 8;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   logic [2:0]        r_state;
   logic [2:0]        w_state_next;
   logic [1:0]        r_op;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_fetch_pend;
   logic [CNT_W-1:0]  r_instr_count;

   dec_ctrl_t w_dec;

   logic w_in_fetch;
   logic w_in_mem;
   logic w_fetch_req;
   logic w_req;
   logic w_done;
   logic w_timeout;
   logic w_retire;

   logic w_pc_write;
   logic w_ir_write;
   logic w_iord;
   logic w_reg_dst;
   logic w_alu_src;
   logic w_mem_to_reg;
   logic w_reg_write;
   logic w_mem_read;
   logic w_mem_write;
   logic w_alu_op;
   logic w_busy;
   logic w_error;

   opcode_decode u_opcode_decode (
      .i_op  (r_op),
      .o_dec (w_dec)
   );

   assign w_in_fetch = (r_state == ST_FETCH);
   assign w_in_mem   = (r_state == ST_MEM);

   // Once a fetch has been issued it stays issued until the memory answers,
   // whatever Hold does in the meantime.
   assign w_fetch_req = w_in_fetch & (~i_hold | r_fetch_pend);
   assign w_req       = w_fetch_req | w_in_mem;
   assign w_done      = w_req & i_mem_ready;

   // A ready on the limit cycle completes the access instead of trapping.
   assign w_timeout   = w_req & ~i_mem_ready & (r_wait_cnt == WAIT_LAST);

   // Stores retire on memory completion, everything else at writeback.
   assign w_retire    = (r_state == ST_WB) |
                        (w_in_mem & i_mem_ready & (r_op == OP_SW));

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_FETCH: begin
            if (w_timeout)
               w_state_next = ST_ERROR;
            else if (w_done)
               w_state_next = ST_DECODE;
         end
         ST_DECODE: w_state_next = ST_EXEC;
         ST_EXEC: begin
            if (is_mem_op(r_op))
               w_state_next = ST_MEM;
            else
               w_state_next = ST_WB;
         end
         ST_MEM: begin
            if (w_timeout)
               w_state_next = ST_ERROR;
            else if (w_done)
               w_state_next = (r_op == OP_SW) ? ST_FETCH : ST_WB;
         end
         ST_WB:    w_state_next = ST_FETCH;
         ST_ERROR: w_state_next = ST_ERROR;
         default:  w_state_next = ST_FETCH;
      endcase
   end

   // ------------------------------------------------------------------
   // State, latched opcode, wait counter, retire counter
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_FETCH;
         r_op          <= OP_RTYPE;
         r_wait_cnt    <= '0;
         r_fetch_pend  <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_state <= w_state_next;

         if (r_state == ST_DECODE)
            r_op <= i_opcode;

         // Any state change clears the counter, which covers entry into
         // FETCH and MEM; completion clears it too.
         if ((w_state_next != r_state) || w_done)
            r_wait_cnt <= '0;
         else if (w_req)
            r_wait_cnt <= r_wait_cnt + 1'b1;

         r_fetch_pend <= w_fetch_req & ~i_mem_ready &
                         (w_state_next == ST_FETCH);

         if (w_retire)
            r_instr_count <= r_instr_count + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Output decode: from state and latched opcode; only the fetch
   // write-enables look at MemReady.
   // ------------------------------------------------------------------
   always_comb begin
      w_pc_write   = 1'b0;
      w_ir_write   = 1'b0;
      w_iord       = 1'b0;
      w_reg_dst    = 1'b0;
      w_alu_src    = 1'b0;
      w_mem_to_reg = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_alu_op     = 1'b0;
      w_busy       = 1'b1;
      w_error      = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_busy     = w_fetch_req;
            w_mem_read = w_fetch_req;
            w_ir_write = w_done;
            w_pc_write = w_done;
         end
         ST_EXEC: begin
            w_alu_src = w_dec.alu_src;
            w_alu_op  = w_dec.alu_op;
         end
         ST_MEM: begin
            w_iord      = 1'b1;
            w_alu_src   = 1'b1;
            w_mem_read  = (r_op == OP_LW);
            w_mem_write = (r_op == OP_SW);
         end
         ST_WB: begin
            w_reg_write  = 1'b1;
            w_reg_dst    = w_dec.reg_dst;
            w_mem_to_reg = w_dec.mem_to_reg;
            // ALU operand selects are kept from EXEC so the ALU result
            // feeding the register file stays stable during the write.
            w_alu_src    = w_dec.alu_src;
            w_alu_op     = w_dec.alu_op;
         end
         ST_ERROR: begin
            w_error = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset forces every output low immediately, even mid-access.
   assign o_pc_write    = w_pc_write   & ~i_rst;
   assign o_ir_write    = w_ir_write   & ~i_rst;
   assign o_iord        = w_iord       & ~i_rst;
   assign o_reg_dst     = w_reg_dst    & ~i_rst;
   assign o_alu_src     = w_alu_src    & ~i_rst;
   assign o_mem_to_reg  = w_mem_to_reg & ~i_rst;
   assign o_reg_write   = w_reg_write  & ~i_rst;
   assign o_mem_read    = w_mem_read   & ~i_rst;
   assign o_mem_write   = w_mem_write  & ~i_rst;
   assign o_alu_op      = w_alu_op     & ~i_rst;
   assign o_busy        = w_busy       & ~i_rst;
   assign o_error       = w_error      & ~i_rst;
   assign o_instr_count = r_instr_count & {CNT_W{~i_rst}};

endmodule
